pipeline_hazard_control: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It decides each cycle whether the PC and the IF/ID, ID/EX and EX/MEM pipeline registers advance, hold, or load a bubble. It covers three cases: load-use interlocks detected against the instruction in ID, taken-branch/jump flushes resolved in EX, and the multi-cycle occupancy of EX by a multiply. It also keeps a saturating count of stalled cycles for performance debug.

---
 rtl/pipeline_hazard_control.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_control.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_control.sv
// Stall/flush sequencer for the five-stage pipeline: load-use interlock, taken-branch flush,
// multi-cycle multiply occupancy of EX, and a saturating stalled-cycle counter.
module pipeline_hazard_control #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_r1,
    input  logic [4:0]       id_r2,
    input  logic             id_uses_r1,
    input  logic             id_uses_r2,
    input  logic             ex_valid,
    input  logic             ex_MemToReg,
    input  logic             ex_RegWrite,
    input  logic [4:0]       ex_destReg,
    input  logic             ex_mul,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } state_t;

    // The first MUL_CYCLES-1 cycles of a multiply stall; cnt counts the remaining MUL-state stalls.
    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 2);

    state_t     state, nextState;
    logic [3:0] cnt, nextCnt;
    logic       mulStart;
    logic       loadUse;
    logic       r1Match;
    logic       r2Match;

    assign r1Match  = id_uses_r1 && (id_r1 == ex_destReg);
    assign r2Match  = id_uses_r2 && (id_r2 == ex_destReg);
    assign loadUse  = ex_valid && ex_MemToReg && ex_RegWrite && (ex_destReg != 5'd0)
                      && id_valid && (r1Match || r2Match);
    assign mulStart = (state == RUN) && ex_valid && ex_mul;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        nextState    = state;
        nextCnt      = cnt;

        case (state)
            RUN: begin
                if (mulStart) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    nextState    = MUL;
                    nextCnt      = CNT_INIT;
                end else if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (loadUse) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MUL: begin
                if (cnt != 4'd0) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    nextCnt      = cnt - 4'd1;
                end else begin
                    // Multiply leaves EX at this edge; a following multiply restarts from RUN.
                    nextState = RUN;
                end
            end
            default: begin
                nextState = RUN;
                nextCnt   = 4'd0;
            end
        endcase

        if (!reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            cnt          <= 4'd0;
            mul_busy     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= nextState;
            cnt      <= nextCnt;
            mul_busy <= (nextState == MUL);
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Directed bench for pipeline_hazard_control: reset forcing, load-use, branch flush,
// multiply sequencing with back-to-back and priority cases, reset mid-multiply, counter saturation.
module tb_pipeline_hazard_control;

    localparam int CNT_W = 16;

    // Control vector order: {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble}
    localparam logic [5:0] C_NORMAL  = 6'b111_000;
    localparam logic [5:0] C_MULST   = 6'b000_001;
    localparam logic [5:0] C_BRANCH  = 6'b111_110;
    localparam logic [5:0] C_LOADUSE = 6'b001_010;
    localparam logic [5:0] C_RESET   = 6'b000_111;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_r1;
    logic [4:0]       id_r2;
    logic             id_uses_r1;
    logic             id_uses_r2;
    logic             ex_valid;
    logic             ex_MemToReg;
    logic             ex_RegWrite;
    logic [4:0]       ex_destReg;
    logic             ex_mul;
    logic             branch_taken;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cycles;

    logic [5:0]       ctrl;
    logic [6:0]       exp_q[$];
    logic [6:0]       expEntry;
    int               nCompared;
    int               nMismatched;

    assign ctrl = {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble};

    pipeline_hazard_control #(
        .MUL_CYCLES(4),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_r1       (id_r1),
        .id_r2       (id_r2),
        .id_uses_r1  (id_uses_r1),
        .id_uses_r2  (id_uses_r2),
        .ex_valid    (ex_valid),
        .ex_MemToReg (ex_MemToReg),
        .ex_RegWrite (ex_RegWrite),
        .ex_destReg  (ex_destReg),
        .ex_mul      (ex_mul),
        .branch_taken(branch_taken),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .idex_write  (idex_write),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .exmem_bubble(exmem_bubble),
        .mul_busy    (mul_busy),
        .stall_cycles(stall_cycles)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        if (obs !== expv) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Driver tasks
    task automatic idleInputs();
        id_valid     = 1'b0;
        id_r1        = 5'd0;
        id_r2        = 5'd0;
        id_uses_r1   = 1'b0;
        id_uses_r2   = 1'b0;
        ex_valid     = 1'b0;
        ex_MemToReg  = 1'b0;
        ex_RegWrite  = 1'b0;
        ex_destReg   = 5'd0;
        ex_mul       = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic driveLoad(input logic [4:0] dest, input logic [4:0] r1, input logic u1,
                             input logic [4:0] r2, input logic u2);
        idleInputs();
        ex_valid    = 1'b1;
        ex_MemToReg = 1'b1;
        ex_RegWrite = 1'b1;
        ex_destReg  = dest;
        id_valid    = 1'b1;
        id_r1       = r1;
        id_uses_r1  = u1;
        id_r2       = r2;
        id_uses_r2  = u2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        idleInputs();
        reset = 1'b0;

        // Reset held low: forced outputs, cleared state
        step();
        step();
        sample();
        checkVal("reset_ctrl", 32'(ctrl), 32'(C_RESET));
        checkVal("reset_stall", 32'(stall_cycles), 32'd0);
        checkVal("reset_busy", 32'(mul_busy), 32'd0);

        step();
        reset = 1'b1;
        sample();
        checkVal("post_reset_ctrl", 32'(ctrl), 32'(C_NORMAL));

        // Load-use on r1
        step();
        driveLoad(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        sample();
        checkVal("lu_r1_ctrl", 32'(ctrl), 32'(C_LOADUSE));
        step();
        idleInputs();
        sample();
        checkVal("lu_r1_after_ctrl", 32'(ctrl), 32'(C_NORMAL));
        checkVal("lu_r1_stall", 32'(stall_cycles), 32'd1);

        // No hazard: r0 destination, unused source, invalid ID
        driveLoad(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        sample();
        checkVal("lu_r0_ctrl", 32'(ctrl), 32'(C_NORMAL));
        step();
        driveLoad(5'd5, 5'd5, 1'b0, 5'd7, 1'b1);
        sample();
        checkVal("lu_unused_ctrl", 32'(ctrl), 32'(C_NORMAL));
        step();
        driveLoad(5'd9, 5'd9, 1'b1, 5'd9, 1'b1);
        id_valid = 1'b0;
        sample();
        checkVal("lu_idinvalid_ctrl", 32'(ctrl), 32'(C_NORMAL));
        step();
        checkVal("no_hazard_stall", 32'(stall_cycles), 32'd1);

        // Load-use on r2
        driveLoad(5'd17, 5'd3, 1'b1, 5'd17, 1'b1);
        sample();
        checkVal("lu_r2_ctrl", 32'(ctrl), 32'(C_LOADUSE));
        step();
        idleInputs();
        checkVal("lu_r2_stall", 32'(stall_cycles), 32'd2);

        // Branch flush, also winning over a simultaneous load-use
        driveLoad(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        branch_taken = 1'b1;
        sample();
        checkVal("branch_ctrl", 32'(ctrl), 32'(C_BRANCH));
        step();
        idleInputs();
        sample();
        checkVal("branch_after_ctrl", 32'(ctrl), 32'(C_NORMAL));
        checkVal("branch_stall", 32'(stall_cycles), 32'd2);

        // Two back-to-back multiplies; load-use and branch present but must be ignored
        step();
        driveLoad(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        ex_mul       = 1'b1;
        ex_MemToReg  = 1'b0;
        exp_q.push_back({1'b0, C_MULST});
        exp_q.push_back({1'b1, C_MULST});
        exp_q.push_back({1'b1, C_MULST});
        exp_q.push_back({1'b1, C_NORMAL});
        exp_q.push_back({1'b0, C_MULST});
        exp_q.push_back({1'b1, C_MULST});
        exp_q.push_back({1'b1, C_MULST});
        exp_q.push_back({1'b1, C_NORMAL});
        for (int i = 0; i < 8; i++) begin
            // Priority check on the first cycle uses a real load-use match
            if (i == 0) ex_MemToReg = 1'b1;
            if (i == 1) branch_taken = 1'b1;
            sample();
            expEntry = exp_q.pop_front();
            checkVal($sformatf("mul_c%0d_ctrl", i + 1), 32'(ctrl), 32'(expEntry[5:0]));
            checkVal($sformatf("mul_c%0d_busy", i + 1), 32'(mul_busy), 32'(expEntry[6]));
            step();
            ex_MemToReg = 1'b0;
        end
        idleInputs();
        sample();
        checkVal("mul_done_ctrl", 32'(ctrl), 32'(C_NORMAL));
        checkVal("mul_done_busy", 32'(mul_busy), 32'd0);
        checkVal("mul_stall", 32'(stall_cycles), 32'd8);

        // Reset pulse mid-multiply while cnt==1
        step();
        ex_valid = 1'b1;
        ex_mul   = 1'b1;
        step();
        step();
        sample();
        checkVal("mid_mul_ctrl", 32'(ctrl), 32'(C_MULST));
        checkVal("mid_mul_stall", 32'(stall_cycles), 32'd10);
        #2;
        reset = 1'b0;
        #1;
        checkVal("mid_mul_reset_busy", 32'(mul_busy), 32'd0);
        checkVal("mid_mul_reset_ctrl", 32'(ctrl), 32'(C_RESET));
        checkVal("mid_mul_reset_stall", 32'(stall_cycles), 32'd0);
        idleInputs();
        step();
        reset = 1'b1;
        sample();
        checkVal("mid_mul_release_ctrl", 32'(ctrl), 32'(C_NORMAL));
        checkVal("mid_mul_release_busy", 32'(mul_busy), 32'd0);
        step();
        checkVal("mid_mul_release_stall", 32'(stall_cycles), 32'd0);

        // Saturation via sustained load-use stalls
        driveLoad(5'd12, 5'd12, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 65534; i++) begin
            step();
        end
        checkVal("sat_preload", 32'(stall_cycles), 32'hFFFE);
        step();
        checkVal("sat_reach", 32'(stall_cycles), 32'hFFFF);
        step();
        step();
        checkVal("sat_hold", 32'(stall_cycles), 32'hFFFF);
        sample();
        checkVal("sat_ctrl", 32'(ctrl), 32'(C_LOADUSE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
